hilo_acc_unit: RTL and testbench
================================

Name: hilo_acc_unit

Overview:
- Parametrised HI/LO special-register block for the MIPS datapath. Sits between the write-back stage and the execute stage.
- Provides independently enabled HI and LO writes, which replaces the single shared write enable.
- Adds a multi-cycle multiply-accumulate engine (MADD/MADDU/MSUB/MSUBU) that updates {HI,LO} in place.
- Raises a busy flag so the pipeline controller can stall, and supports flush of an in-flight accumulate.

Parameters:
- DW, 32, data width of HI, LO and the multiply operands. Product and accumulator width is 2*DW.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  synchronous, active-high reset
- we_hi  input  1  write hi_i into HI
- we_lo  input  1  write lo_i into LO
- hi_i  input  DW  HI write data
- lo_i  input  DW  LO write data
- acc_valid  input  1  start an accumulate; sampled only when acc_busy=0
- acc_op  input  2  00 MADD (signed), 01 MADDU, 10 MSUB (signed), 11 MSUBU
- acc_a  input  DW  multiplicand
- acc_b  input  DW  multiplier
- flush  input  1  abort any in-flight accumulate
- acc_busy  output  1  accumulate in flight
- acc_done  output  1  one-cycle pulse on the cycle the accumulate result is committed
- hi_o  output  DW  committed HI
- lo_o  output  DW  committed LO

Behaviour:
- Reset (rst=1 at posedge): hi_o=0, lo_o=0, FSM=IDLE, acc_busy=0, acc_done=0, latched operands=0. Reset has priority over every other input, including mid-operation; an in-flight accumulate is discarded.
- Direct writes: at the posedge, we_hi loads HI from hi_i and we_lo loads LO from lo_i, independently. A half that is not enabled holds its value. Writes take effect on hi_o/lo_o the next cycle; there is no combinational bypass.
- FSM states:
  - IDLE: acc_valid=1 and flush=0 latches acc_a, acc_b, acc_op, then -> MUL. acc_busy=0.
  - MUL: computes the registered 2*DW product. Signed ops sign-extend both operands; unsigned ops zero-extend. -> ACC. acc_busy=1.
  - ACC: computes {HI,LO} ± product modulo 2^(2*DW) using the register values present in this cycle, commits at the posedge, pulses acc_done, -> IDLE. acc_busy=1.
- Latency: start accepted at cycle t; result visible on hi_o/lo_o at t+3; acc_done is high during cycle t+2.
- acc_busy is registered and deasserts the cycle after ACC. A new acc_valid can therefore be accepted on the cycle acc_done is high? No: acc_busy=1 in that cycle, so acc_valid is ignored. The earliest new start is t+3.
- acc_valid while acc_busy=1 is ignored; the stall is the controller's responsibility.
- Simultaneous direct write and ACC commit: the direct write wins for each enabled half, because the direct write comes from the younger instruction. The non-enabled half takes the accumulate result. acc_done still pulses.
- Direct write during MUL: the write is applied, and ACC then accumulates onto the newly written value.
- flush=1 in MUL or ACC: FSM -> IDLE, no accumulate commit, no acc_done. Direct writes in the same cycle are still applied. flush in IDLE blocks a start that cycle.
- No overflow trap: arithmetic wraps silently.

Test Plan:
- Reset, then we_lo=1 with lo_i=0x0000AABB and we_hi=0 -> lo_o=0x0000AABB, hi_o=0. Then we_hi=1, hi_i=0x12345678 -> hi_o=0x12345678, lo_o unchanged.
- HI:LO=0:5, MADD a=3, b=4 -> acc_busy high for 2 cycles, acc_done pulse at t+2, HI:LO=0:0x11 at t+3.
- HI:LO=0:0, MSUB a=0xFFFFFFFF, b=1 -> 0:1. Repeat with MSUBU -> HI=0xFFFFFFFF, LO=0x00000001.
- HI:LO=0xFFFFFFFF:0xFFFFFFFF, MADDU a=1, b=1 -> wraps to 0:0, no error.
- MADD in flight with we_hi=1, hi_i=0xDEAD0000 in the ACC cycle -> HI=0xDEAD0000, LO=accumulated value.
- Start MADD then flush in MUL -> HI/LO unchanged, no acc_done. Start MADD then rst in ACC -> all outputs 0, acc_busy=0.

Source files
------------

// File: rtl/hilo_acc_unit.sv
// HI/LO special registers with independent half writes and a two-cycle
// multiply-accumulate engine (MADD/MADDU/MSUB/MSUBU) that updates {HI,LO} in place.
module hilo_acc_unit #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we_hi,
    input  logic          we_lo,
    input  logic [DW-1:0] hi_i,
    input  logic [DW-1:0] lo_i,
    input  logic          acc_valid,
    input  logic [1:0]    acc_op,
    input  logic [DW-1:0] acc_a,
    input  logic [DW-1:0] acc_b,
    input  logic          flush,
    output logic          acc_busy,
    output logic          acc_done,
    output logic [DW-1:0] hi_o,
    output logic [DW-1:0] lo_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_ACC  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_busy;
    logic            w_commit;

    logic [DW-1:0]   r_hi;
    logic [DW-1:0]   r_lo;
    logic [DW-1:0]   r_a_p0;
    logic [DW-1:0]   r_b_p0;
    logic [1:0]      r_op_p0;
    logic [2*DW-1:0] r_prod_p1;

    logic [2*DW-1:0] w_a_ext;
    logic [2*DW-1:0] w_b_ext;
    logic [2*DW-1:0] w_prod;
    logic [2*DW-1:0] w_acc_cur;
    logic [2*DW-1:0] w_acc_nxt;

    // Widen an operand to 2*DW; the low 2*DW bits of the widened product are
    // then exact for both signed and unsigned operands.
    function automatic logic [2*DW-1:0] widen(input logic [DW-1:0] v, input logic sgn);
        return sgn ? {{DW{v[DW-1]}}, v} : {{DW{1'b0}}, v};
    endfunction

    function automatic logic [2*DW-1:0] accumulate(input logic [2*DW-1:0] acc,
                                                   input logic [2*DW-1:0] prod,
                                                   input logic            sub);
        return sub ? (acc - prod) : (acc + prod);
    endfunction

    always_comb begin
        w_state_nxt = r_state;
        w_commit    = 1'b0;
        case (r_state)
            S_IDLE: if (acc_valid && !flush) w_state_nxt = S_MUL;
            S_MUL:  w_state_nxt = flush ? S_IDLE : S_ACC;
            S_ACC: begin
                w_state_nxt = S_IDLE;
                w_commit    = !flush && !rst;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
        end
    end

    // Stage p0: operand latch on start
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_p0  <= '0;
            r_b_p0  <= '0;
            r_op_p0 <= '0;
        end else if (r_state == S_IDLE && acc_valid && !flush) begin
            r_a_p0  <= acc_a;
            r_b_p0  <= acc_b;
            r_op_p0 <= acc_op;
        end
    end

    // Stage p1: registered product, computed during MUL
    assign w_a_ext = widen(r_a_p0, ~r_op_p0[0]);
    assign w_b_ext = widen(r_b_p0, ~r_op_p0[0]);
    assign w_prod  = w_a_ext * w_b_ext;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prod_p1 <= '0;
        end else if (r_state == S_MUL) begin
            r_prod_p1 <= w_prod;
        end
    end

    // Stage p2: accumulate onto the live HI/LO; direct writes override per half
    assign w_acc_cur = {r_hi, r_lo};
    assign w_acc_nxt = accumulate(w_acc_cur, r_prod_p1, r_op_p0[1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi <= '0;
            r_lo <= '0;
        end else begin
            if (we_hi)         r_hi <= hi_i;
            else if (w_commit) r_hi <= w_acc_nxt[2*DW-1:DW];
            if (we_lo)         r_lo <= lo_i;
            else if (w_commit) r_lo <= w_acc_nxt[DW-1:0];
        end
    end

    assign acc_busy = r_busy;
    assign acc_done = w_commit;
    assign hi_o     = r_hi;
    assign lo_o     = r_lo;

endmodule

// File: tb/tb_hilo_acc_unit.sv
// Scoreboard bench for hilo_acc_unit: expected {HI,LO} results are queued when
// an accumulate is launched and compared when the DUT commits it.
module tb_hilo_acc_unit;

    localparam int DW = 32;

    logic          clk;
    logic          rst;
    logic          we_hi;
    logic          we_lo;
    logic [DW-1:0] hi_i;
    logic [DW-1:0] lo_i;
    logic          acc_valid;
    logic [1:0]    acc_op;
    logic [DW-1:0] acc_a;
    logic [DW-1:0] acc_b;
    logic          flush;
    logic          acc_busy;
    logic          acc_done;
    logic [DW-1:0] hi_o;
    logic [DW-1:0] lo_o;

    int total = 0;
    int bad   = 0;

    logic [63:0] sb[$];
    logic [63:0] m_hilo;
    logic [63:0] exp_v;

    hilo_acc_unit #(.DW(DW)) dut (
        .clk(clk), .rst(rst),
        .we_hi(we_hi), .we_lo(we_lo), .hi_i(hi_i), .lo_i(lo_i),
        .acc_valid(acc_valid), .acc_op(acc_op), .acc_a(acc_a), .acc_b(acc_b),
        .flush(flush), .acc_busy(acc_busy), .acc_done(acc_done),
        .hi_o(hi_o), .lo_o(lo_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    function automatic logic [63:0] model(input logic [63:0] acc, input logic [1:0] op,
                                          input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sbv;
        logic [63:0] p;
        if (!op[0]) begin
            sa  = longint'($signed(a));
            sbv = longint'($signed(b));
            p   = sa * sbv;
        end else begin
            p = {32'b0, a} * {32'b0, b};
        end
        return op[1] ? (acc - p) : (acc + p);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_hilo(input logic [31:0] h, input logic [31:0] l);
        we_hi = 1'b1; we_lo = 1'b1; hi_i = h; lo_i = l;
        tick();
        we_hi = 1'b0; we_lo = 1'b0;
        m_hilo = {h, l};
    endtask

    task automatic run_acc(input string name, input logic [1:0] op,
                           input logic [31:0] a, input logic [31:0] b);
        int waits;
        bit found;
        acc_valid = 1'b1; acc_op = op; acc_a = a; acc_b = b;
        sb.push_back(model(m_hilo, op, a, b));
        tick();
        acc_valid = 1'b0;
        total++;
        if (acc_busy !== 1'b1) begin
            bad++; $display("FAIL %s_busy_mul actual=%b required=1", name, acc_busy);
        end
        waits = 0; found = 0;
        for (int i = 0; i < 5 && !found; i++) begin
            if (acc_done === 1'b1) found = 1;
            else begin tick(); waits++; end
        end
        total++;
        if (!found || waits != 1) begin
            bad++; $display("FAIL %s_done_latency actual=found%0d_wait%0d required=found1_wait1", name, found, waits);
        end
        tick();
        exp_v = sb.pop_front();
        m_hilo = exp_v;
        total++;
        if ({hi_o, lo_o} !== exp_v) begin
            bad++; $display("FAIL %s_result actual=%h required=%h", name, {hi_o, lo_o}, exp_v);
        end
        total++;
        if (acc_busy !== 1'b0 || acc_done !== 1'b0) begin
            bad++; $display("FAIL %s_idle actual=busy%b_done%b required=busy0_done0", name, acc_busy, acc_done);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        m_hilo = '0;
        total++;
        if ({hi_o, lo_o, acc_busy, acc_done} !== 66'b0) begin
            bad++; $display("FAIL reset actual=%h_%h_%b_%b required=0", hi_o, lo_o, acc_busy, acc_done);
        end
    endtask

    task automatic test_direct_write();
        we_lo = 1'b1; lo_i = 32'h0000AABB;
        tick();
        we_lo = 1'b0;
        total++;
        if (lo_o !== 32'h0000AABB || hi_o !== 32'h0) begin
            bad++; $display("FAIL write_lo actual=%h:%h required=00000000:0000aabb", hi_o, lo_o);
        end
        we_hi = 1'b1; hi_i = 32'h12345678; lo_i = 32'hFFFF0000;
        tick();
        we_hi = 1'b0;
        total++;
        if (hi_o !== 32'h12345678 || lo_o !== 32'h0000AABB) begin
            bad++; $display("FAIL write_hi actual=%h:%h required=12345678:0000aabb", hi_o, lo_o);
        end
        m_hilo = {32'h12345678, 32'h0000AABB};
    endtask

    task automatic test_madd_msub();
        set_hilo(32'h0, 32'h5);
        run_acc("madd", 2'b00, 32'd3, 32'd4);
        total++;
        if ({hi_o, lo_o} !== 64'h0000_0000_0000_0011) begin
            bad++; $display("FAIL madd_const actual=%h required=0000000000000011", {hi_o, lo_o});
        end
        set_hilo(32'h0, 32'h0);
        run_acc("msub", 2'b10, 32'hFFFFFFFF, 32'd1);
        set_hilo(32'h0, 32'h0);
        run_acc("msubu", 2'b11, 32'hFFFFFFFF, 32'd1);
        total++;
        if ({hi_o, lo_o} !== 64'hFFFF_FFFF_0000_0001) begin
            bad++; $display("FAIL msubu_const actual=%h required=ffffffff00000001", {hi_o, lo_o});
        end
        set_hilo(32'hFFFFFFFF, 32'hFFFFFFFF);
        run_acc("maddu_wrap", 2'b01, 32'd1, 32'd1);
        set_hilo(32'h00000010, 32'h80000000);
        run_acc("madd_neg", 2'b00, 32'hFFFF8000, 32'h00012345);
        run_acc("maddu_big", 2'b01, 32'hFFFF8000, 32'h80012345);
    endtask

    task automatic test_write_during_acc();
        set_hilo(32'h1, 32'h2);
        acc_valid = 1'b1; acc_op = 2'b00; acc_a = 32'd3; acc_b = 32'd4;
        tick();
        acc_valid = 1'b0;
        we_lo = 1'b1; lo_i = 32'h100;
        tick();
        we_lo = 1'b0;
        m_hilo = {32'h1, 32'h100};
        total++;
        if (acc_done !== 1'b1) begin
            bad++; $display("FAIL wr_done actual=%b required=1", acc_done);
        end
        we_hi = 1'b1; hi_i = 32'hDEAD0000;
        exp_v = model(m_hilo, 2'b00, 32'd3, 32'd4);
        sb.push_back({32'hDEAD0000, exp_v[31:0]});
        tick();
        we_hi = 1'b0;
        exp_v = sb.pop_front();
        m_hilo = exp_v;
        total++;
        if ({hi_o, lo_o} !== exp_v) begin
            bad++; $display("FAIL wr_collide actual=%h required=%h", {hi_o, lo_o}, exp_v);
        end
    endtask

    task automatic test_back_to_back();
        set_hilo(32'h0, 32'h64);
        acc_valid = 1'b1; acc_op = 2'b00; acc_a = 32'd2; acc_b = 32'd5;
        sb.push_back(model(m_hilo, 2'b00, 32'd2, 32'd5));
        tick();
        acc_op = 2'b01; acc_a = 32'd100; acc_b = 32'd100;
        tick();
        total++;
        if (acc_done !== 1'b1 || acc_busy !== 1'b1) begin
            bad++; $display("FAIL b2b_first_done actual=done%b_busy%b required=done1_busy1", acc_done, acc_busy);
        end
        tick();
        exp_v = sb.pop_front();
        m_hilo = exp_v;
        total++;
        if ({hi_o, lo_o} !== exp_v || acc_busy !== 1'b0) begin
            bad++; $display("FAIL b2b_first actual=%h_busy%b required=%h_busy0", {hi_o, lo_o}, acc_busy, exp_v);
        end
        acc_op = 2'b10; acc_a = 32'd7; acc_b = 32'd9;
        sb.push_back(model(m_hilo, 2'b10, 32'd7, 32'd9));
        tick();
        acc_valid = 1'b0;
        tick();
        total++;
        if (acc_done !== 1'b1) begin
            bad++; $display("FAIL b2b_second_done actual=%b required=1", acc_done);
        end
        tick();
        exp_v = sb.pop_front();
        m_hilo = exp_v;
        total++;
        if ({hi_o, lo_o} !== exp_v) begin
            bad++; $display("FAIL b2b_second actual=%h required=%h", {hi_o, lo_o}, exp_v);
        end
    endtask

    task automatic test_flush();
        int seen;
        set_hilo(32'h0, 32'h7);
        acc_valid = 1'b1; acc_op = 2'b00; acc_a = 32'd3; acc_b = 32'd4;
        tick();
        acc_valid = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        seen = (acc_done === 1'b1) ? 1 : 0;
        total++;
        if (acc_busy !== 1'b0) begin
            bad++; $display("FAIL flush_mul_busy actual=%b required=0", acc_busy);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            if (acc_done === 1'b1) seen++;
        end
        total++;
        if (seen != 0 || {hi_o, lo_o} !== m_hilo) begin
            bad++; $display("FAIL flush_mul actual=%h_done%0d required=%h_done0", {hi_o, lo_o}, seen, m_hilo);
        end
        acc_valid = 1'b1;
        tick();
        acc_valid = 1'b0;
        tick();
        flush = 1'b1; we_lo = 1'b1; lo_i = 32'h55;
        #1;
        total++;
        if (acc_done !== 1'b0) begin
            bad++; $display("FAIL flush_acc_done actual=%b required=0", acc_done);
        end
        tick();
        flush = 1'b0; we_lo = 1'b0;
        m_hilo = {m_hilo[63:32], 32'h55};
        total++;
        if ({hi_o, lo_o} !== m_hilo || acc_busy !== 1'b0) begin
            bad++; $display("FAIL flush_acc actual=%h_busy%b required=%h_busy0", {hi_o, lo_o}, acc_busy, m_hilo);
        end
        acc_valid = 1'b1; flush = 1'b1;
        tick();
        acc_valid = 1'b0; flush = 1'b0;
        total++;
        if (acc_busy !== 1'b0) begin
            bad++; $display("FAIL flush_idle actual=%b required=0", acc_busy);
        end
    endtask

    task automatic test_rst_mid();
        set_hilo(32'hA5A5A5A5, 32'h5A5A5A5A);
        acc_valid = 1'b1; acc_op = 2'b00; acc_a = 32'd3; acc_b = 32'd4;
        tick();
        acc_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_hilo = '0;
        total++;
        if ({hi_o, lo_o, acc_busy, acc_done} !== 66'b0) begin
            bad++; $display("FAIL rst_mid actual=%h_%h_%b_%b required=0", hi_o, lo_o, acc_busy, acc_done);
        end
        tick();
        total++;
        if (acc_busy !== 1'b0 || acc_done !== 1'b0 || {hi_o, lo_o} !== 64'h0) begin
            bad++; $display("FAIL rst_mid_after actual=%h_%b_%b required=0", {hi_o, lo_o}, acc_busy, acc_done);
        end
    endtask

    initial begin
        rst = 1'b0; we_hi = 1'b0; we_lo = 1'b0; hi_i = '0; lo_i = '0;
        acc_valid = 1'b0; acc_op = '0; acc_a = '0; acc_b = '0; flush = 1'b0;
        m_hilo = '0;
        test_reset();
        test_direct_write();
        test_madd_msub();
        test_write_during_acc();
        test_back_to_back();
        test_flush();
        test_rst_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
